// File: rtl/perf_run_ctrl.sv
// ============================================================================
// Module   : perf_run_ctrl
// Purpose  : Run sequencing, halt drain, cycle-budget watchdog and
//            performance counters (cycles / retired / bubbles) with readback.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module perf_run_ctrl #(
    parameter int CYCLE_W      = 32,
    parameter int MAX_CYCLES   = 100000,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               isHalt,
    input  logic               W_v,
    output logic               run,
    output logic               done,
    output logic               timeout,
    output logic [CYCLE_W-1:0] cycle,
    input  logic [1:0]         rd_sel,
    output logic [CYCLE_W-1:0] rd_data
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CYCLE_W-1:0] c_last_cycle = CYCLE_W'(MAX_CYCLES - 1);
    localparam logic [DW-1:0]      c_drain_load = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_DRAIN   = 3'd2,
        S_DONE    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CYCLE_W-1:0] r_cyc_cnt;
    logic [CYCLE_W-1:0] r_ins_cnt;
    logic [CYCLE_W-1:0] r_bub_cnt;
    logic [DW-1:0]      r_drain_cnt;
    logic               r_run;
    logic               r_done;
    logic               r_timeout;
    logic               w_clear;

    function automatic logic [CYCLE_W-1:0] f_sat_inc(input logic [CYCLE_W-1:0] v,
                                                     input logic               en);
        return (en && (v != '1)) ? v + CYCLE_W'(1) : v;
    endfunction

    // start only matters in the resting states; it is dropped in RUN and DRAIN
    assign w_clear = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                               (r_state == S_TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start) w_state_nxt = S_RUN;
            S_RUN: begin
                if (isHalt)                         w_state_nxt = S_DRAIN;
                else if (r_cyc_cnt == c_last_cycle) w_state_nxt = S_TIMEOUT;
            end
            S_DRAIN:   if (r_drain_cnt == '0) w_state_nxt = S_DONE;
            S_DONE:    if (start) w_state_nxt = S_RUN;
            S_TIMEOUT: if (start) w_state_nxt = S_RUN;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc_cnt   <= '0;
            r_ins_cnt   <= '0;
            r_bub_cnt   <= '0;
            r_drain_cnt <= '0;
        end else if (w_clear) begin
            r_cyc_cnt   <= '0;
            r_ins_cnt   <= '0;
            r_bub_cnt   <= '0;
            r_drain_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_cyc_cnt <= f_sat_inc(r_cyc_cnt, 1'b1);
            r_ins_cnt <= f_sat_inc(r_ins_cnt, W_v);
            r_bub_cnt <= f_sat_inc(r_bub_cnt, !W_v);
            if (isHalt) r_drain_cnt <= c_drain_load;
        end else if (r_state == S_DRAIN) begin
            // late retirements still count, but cycles and bubbles are closed
            r_ins_cnt <= f_sat_inc(r_ins_cnt, W_v);
            if (r_drain_cnt != '0) r_drain_cnt <= r_drain_cnt - DW'(1);
        end
    end

    // Status flags follow the state one cycle later; no input-to-output path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run     <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_run     <= (r_state == S_RUN);
            r_done    <= (r_state == S_DONE) || (r_state == S_TIMEOUT);
            r_timeout <= (r_state == S_TIMEOUT);
        end
    end

    assign run     = r_run;
    assign done    = r_done;
    assign timeout = r_timeout;
    assign cycle   = r_cyc_cnt;

    always_comb begin
        rd_data = '0;
        case (rd_sel)
            2'd0:    rd_data = r_cyc_cnt;
            2'd1:    rd_data = r_ins_cnt;
            2'd2:    rd_data = r_bub_cnt;
            default: rd_data = CYCLE_W'({r_timeout, r_done, r_state});
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_perf_run_ctrl.sv
// ============================================================================
// Module   : tb_perf_run_ctrl
// Purpose  : Randomised self-checking bench for perf_run_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_perf_run_ctrl;

    localparam int CW    = 32;
    localparam int MAXC  = 20;
    localparam int DRAIN = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          isHalt = 1'b0;
    logic          W_v = 1'b0;
    logic          run, done, timeout;
    logic [CW-1:0] cycle;
    logic [1:0]    rd_sel = 2'd0;
    logic [CW-1:0] rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    // stimulus for one run: retirements per RUN cycle and per DRAIN cycle
    bit      wv[0:31];
    bit      dwv[0:DRAIN-1];
    int      exp_cyc, exp_ins, exp_bub, exp_run_ins;
    bit      exp_to;

    perf_run_ctrl #(.CYCLE_W(CW), .MAX_CYCLES(MAXC), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .isHalt(isHalt), .W_v(W_v),
        .run(run), .done(done), .timeout(timeout), .cycle(cycle),
        .rd_sel(rd_sel), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] sel, output logic [CW-1:0] v);
        rd_sel = sel;
        #1;
        v = rd_data;
    endtask

    // Full run: start, RUN cycles, optional halt + drain, settle into DONE/TIMEOUT.
    // halt_at==0 or > MAXC means the watchdog ends the run.
    task automatic exec_run(input int halt_at, input bit poke_start);
        bit            halted;
        int            sum_drain;
        logic [CW-1:0] v, bub;
        halted      = (halt_at > 0) && (halt_at <= MAXC);
        exp_cyc     = halted ? halt_at : MAXC;
        exp_run_ins = 0;
        for (int i = 0; i < exp_cyc; i++) exp_run_ins += int'(wv[i]);
        sum_drain = 0;
        if (halted) for (int d = 0; d < DRAIN; d++) sum_drain += int'(dwv[d]);
        exp_ins = exp_run_ins + sum_drain;
        exp_bub = exp_cyc - exp_run_ins;
        exp_to  = !halted;

        start = 1'b1; isHalt = 1'b0; W_v = 1'($urandom);
        step();
        start = 1'b0;
        n_checks++;
        if (cycle !== '0) begin n_fail++; $display("FAIL start_clear: cycle=%0d want 0", cycle); end
        for (int i = 0; i < exp_cyc; i++) begin
            W_v    = wv[i];
            isHalt = halted && (i == exp_cyc - 1);
            start  = poke_start && (i == 2);
            step();
            if (i == 0) begin
                n_checks++;
                if (cycle !== 32'd1) begin n_fail++; $display("FAIL first_count: cycle=%0d want 1", cycle); end
            end
        end
        start = 1'b0; isHalt = 1'b0;
        n_checks++;
        if (run !== 1'b1) begin n_fail++; $display("FAIL run_high: run=%b want 1", run); end
        if (halted) begin
            for (int d = 0; d < DRAIN; d++) begin
                W_v    = dwv[d];
                isHalt = 1'($urandom);
                start  = poke_start && (d == 1);
                step();
                if (d == 0) begin
                    n_checks++;
                    if (run !== 1'b0) begin n_fail++; $display("FAIL run_fall: run=%b want 0", run); end
                end
            end
            start = 1'b0; isHalt = 1'b0;
            n_checks++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL done_early: done=%b want 0", done); end
        end
        W_v = 1'($urandom);
        step();
        W_v = 1'b0;
        n_checks++;
        if (done !== 1'b1 || timeout !== exp_to || run !== 1'b0) begin
            n_fail++;
            $display("FAIL end_flags: done=%b timeout=%b run=%b want 1 %b 0", done, timeout, run, exp_to);
        end
        rd(2'd0, v);
        n_checks++;
        if (v !== CW'(exp_cyc) || cycle !== CW'(exp_cyc)) begin
            n_fail++; $display("FAIL cyc_cnt: rd=%0d cycle=%0d want %0d", v, cycle, exp_cyc);
        end
        rd(2'd1, v);
        n_checks++;
        if (v !== CW'(exp_ins)) begin n_fail++; $display("FAIL ins_cnt: got %0d want %0d", v, exp_ins); end
        rd(2'd2, bub);
        n_checks++;
        if (bub !== CW'(exp_bub)) begin n_fail++; $display("FAIL bub_cnt: got %0d want %0d", bub, exp_bub); end
        n_checks++;
        if (cycle !== CW'(exp_run_ins) + bub) begin
            n_fail++; $display("FAIL invariant: cyc=%0d run_ins+bub=%0d", cycle, CW'(exp_run_ins) + bub);
        end
        rd(2'd3, v);
        n_checks++;
        if (v !== (exp_to ? 32'h1C : 32'h0B)) begin
            n_fail++; $display("FAIL status: got 0x%0h want 0x%0h", v, exp_to ? 32'h1C : 32'h0B);
        end
    endtask

    task automatic test_reset();
        logic [CW-1:0] v;
        rst_n = 1'b0;
        #1;
        rd(2'd3, v);
        n_checks++;
        if (run !== 1'b0 || done !== 1'b0 || timeout !== 1'b0 || cycle !== '0 || v !== '0) begin
            n_fail++;
            $display("FAIL reset_state: run=%b done=%b to=%b cycle=%0d status=0x%0h want all 0",
                     run, done, timeout, cycle, v);
        end
        step();
        rst_n = 1'b1;
        W_v = 1'b1;
        repeat (3) step();
        rd(2'd1, v);
        n_checks++;
        if (v !== '0 || cycle !== '0 || run !== 1'b0) begin
            n_fail++; $display("FAIL idle_hold: ins=%0d cycle=%0d run=%b want 0 0 0", v, cycle, run);
        end
    endtask

    task automatic test_halt_basic();
        for (int i = 0; i < 32; i++) wv[i] = 1'b1;
        for (int d = 0; d < DRAIN; d++) dwv[d] = 1'b0;
        exec_run(10, 1'b0);
    endtask

    task automatic test_alternating();
        for (int i = 0; i < 32; i++) wv[i] = (i % 2 == 0);
        dwv[0] = 1'b1; dwv[1] = 1'b1; dwv[2] = 1'b0; dwv[3] = 1'b0;
        exec_run(8, 1'b0);
    endtask

    task automatic test_timeout();
        logic [CW-1:0] v;
        for (int i = 0; i < 32; i++) wv[i] = 1'b1;
        exec_run(0, 1'b0);
        for (int k = 0; k < 50; k++) begin
            W_v = 1'($urandom); isHalt = 1'($urandom);
            step();
            n_checks++;
            if (timeout !== 1'b1 || done !== 1'b1 || cycle !== CW'(MAXC)) begin
                n_fail++;
                $display("FAIL timeout_sticky: to=%b done=%b cycle=%0d want 1 1 %0d", timeout, done, cycle, MAXC);
            end
        end
        W_v = 1'b0; isHalt = 1'b0;
        rd(2'd1, v);
        n_checks++;
        if (v !== CW'(MAXC)) begin n_fail++; $display("FAIL timeout_ins: got %0d want %0d", v, MAXC); end
    endtask

    task automatic test_halt_at_budget();
        for (int i = 0; i < 32; i++) wv[i] = 1'($urandom);
        for (int d = 0; d < DRAIN; d++) dwv[d] = 1'($urandom);
        exec_run(MAXC, 1'b0);
    endtask

    task automatic test_reset_midrun();
        logic [CW-1:0] v;
        start = 1'b1;
        step();
        start = 1'b0; W_v = 1'b1;
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        rd(2'd3, v);
        n_checks++;
        if (run !== 1'b0 || done !== 1'b0 || timeout !== 1'b0 || cycle !== '0 || v !== '0) begin
            n_fail++;
            $display("FAIL async_reset: run=%b done=%b to=%b cycle=%0d status=0x%0h want all 0",
                     run, done, timeout, cycle, v);
        end
        step();
        rst_n = 1'b1;
        step();
        rd(2'd1, v);
        n_checks++;
        if (v !== '0 || cycle !== '0) begin
            n_fail++; $display("FAIL post_reset_idle: ins=%0d cycle=%0d want 0 0", v, cycle);
        end
        W_v = 1'b0;
    endtask

    task automatic test_start_ignored();
        for (int i = 0; i < 32; i++) wv[i] = 1'($urandom);
        for (int d = 0; d < DRAIN; d++) dwv[d] = 1'($urandom);
        exec_run(12, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 32; i++) wv[i] = 1'($urandom);
        for (int d = 0; d < DRAIN; d++) dwv[d] = 1'($urandom);
        exec_run(7, 1'b0);
        exec_run(15, 1'b0);
    endtask

    task automatic test_readback();
        logic [CW-1:0] want [4];
        for (int i = 0; i < 32; i++) wv[i] = 1'($urandom);
        for (int d = 0; d < DRAIN; d++) dwv[d] = 1'($urandom);
        exec_run(int'($urandom_range(3, 18)), 1'b0);
        want[0] = CW'(exp_cyc); want[1] = CW'(exp_ins);
        want[2] = CW'(exp_bub); want[3] = 32'h0B;
        for (int k = 0; k < 6; k++) begin
            W_v = ~W_v;
            step();
        end
        W_v = 1'b0;
        for (int s = 0; s < 4; s++) begin
            rd_sel = 2'(s);
            #1;
            n_checks++;
            if (rd_data !== want[s]) begin
                n_fail++; $display("FAIL readback_sel%0d: got %0d want %0d", s, rd_data, want[s]);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 32; i++) wv[i] = 1'($urandom);
            for (int d = 0; d < DRAIN; d++) dwv[d] = 1'($urandom);
            exec_run(int'($urandom_range(0, 25)), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_halt_basic();
        test_alternating();
        test_timeout();
        test_halt_at_budget();
        test_reset_midrun();
        test_start_ignored();
        test_back_to_back();
        test_readback();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
